// File: rtl/rob_pkg.sv
// Shared ROB/RAT/PRF widths and helpers for the two-way out-of-order core.
package rob_pkg;

  localparam int unsigned SCALAR  = 2;
  localparam int unsigned RAT_IDX = 5;
  localparam int unsigned PRF_IDX = 6;
  localparam int unsigned ROB_SZ  = 32;
  localparam int unsigned ROB_IDX = 5;

  localparam logic [RAT_IDX-1:0] ZERO_REG = '0;

  function automatic int unsigned popcnt(input logic [SCALAR-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SCALAR; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocation and commit of up to SCALAR ops per cycle,
// with flush on retirement of a mispredicted branch.
module rob
  import rob_pkg::*;
#(
  parameter int unsigned ROB_SZ  = rob_pkg::ROB_SZ,
  parameter int unsigned ROB_IDX = rob_pkg::ROB_IDX
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [SCALAR-1:0]               dispatch,
  input  logic [SCALAR-1:0][RAT_IDX-1:0]  dispatch_dest_idx,
  input  logic [SCALAR-1:0][PRF_IDX-1:0]  dispatch_pdest_idx,
  output logic [SCALAR-1:0][ROB_IDX-1:0]  rob_idx_out,
  output logic [1:0]                      rob_avail,
  input  logic [SCALAR-1:0]               complete,
  input  logic [SCALAR-1:0][ROB_IDX-1:0]  complete_rob_idx,
  input  logic [SCALAR-1:0]               complete_mispred,
  output logic [SCALAR-1:0]               retire,
  output logic [SCALAR-1:0][RAT_IDX-1:0]  retire_dest_idx_out,
  output logic [SCALAR-1:0][PRF_IDX-1:0]  retire_pdest_idx_out,
  output logic                            flush
);

  typedef logic [ROB_IDX-1:0] idx_t;
  typedef logic [ROB_IDX:0]   cnt_t;

  idx_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  logic [ROB_SZ-1:0]              valid_q, valid_d;
  logic [ROB_SZ-1:0]              done_q, done_d;
  logic [ROB_SZ-1:0]              mispred_q, mispred_d;
  logic [ROB_SZ-1:0][RAT_IDX-1:0] dest_q, dest_d;
  logic [ROB_SZ-1:0][PRF_IDX-1:0] pdest_q, pdest_d;

  int unsigned n_disp;
  logic        accept;

  // Outputs depend only on registered state and the current dispatch mask.
  always_comb begin
    int unsigned free;
    int unsigned offset;
    idx_t        ridx;
    logic        ok;
    logic        r;
    free      = ROB_SZ - 32'(count_q);
    rob_avail = (free >= 2) ? 2'd2 : 2'(free);
    n_disp    = popcnt(dispatch);
    accept    = (n_disp <= 32'(rob_avail));

    offset = 0;
    for (int w = 0; w < SCALAR; w++) begin
      rob_idx_out[w] = tail_q + idx_t'(offset);
      if (dispatch[w]) offset++;
    end

    ok    = 1'b1;
    flush = 1'b0;
    ridx  = '0;
    for (int w = 0; w < SCALAR; w++) begin
      ridx                    = head_q + idx_t'(w);
      r                       = ok & valid_q[ridx] & done_q[ridx];
      retire[w]               = r;
      retire_dest_idx_out[w]  = r ? dest_q[ridx]  : '0;
      retire_pdest_idx_out[w] = r ? pdest_q[ridx] : '0;
      if (r && mispred_q[ridx]) flush = 1'b1;
      // A retiring mispredict blocks everything younger.
      ok = r & ~mispred_q[ridx];
    end
  end

  always_comb begin
    int unsigned n_ret;
    int unsigned n_acc;
    valid_d   = valid_q;
    done_d    = done_q;
    mispred_d = mispred_q;
    dest_d    = dest_q;
    pdest_d   = pdest_q;
    head_d    = head_q;
    tail_d    = tail_q;
    n_ret     = popcnt(retire);
    n_acc     = accept ? n_disp : 0;

    // Later ways overwrite earlier ones, so way1 wins on a shared index.
    for (int w = 0; w < SCALAR; w++) begin
      if (complete[w] && valid_q[complete_rob_idx[w]]) begin
        done_d[complete_rob_idx[w]]    = 1'b1;
        mispred_d[complete_rob_idx[w]] = complete_mispred[w];
      end
    end

    for (int w = 0; w < SCALAR; w++) begin
      if (retire[w]) valid_d[head_q + idx_t'(w)] = 1'b0;
    end
    head_d = head_q + idx_t'(n_ret);

    if (accept) begin
      for (int w = 0; w < SCALAR; w++) begin
        if (dispatch[w]) begin
          valid_d[rob_idx_out[w]]   = 1'b1;
          done_d[rob_idx_out[w]]    = 1'b0;
          mispred_d[rob_idx_out[w]] = 1'b0;
          dest_d[rob_idx_out[w]]    = dispatch_dest_idx[w];
          pdest_d[rob_idx_out[w]]   = dispatch_pdest_idx[w];
        end
      end
      tail_d = tail_q + idx_t'(n_disp);
    end
    count_d = cnt_t'(32'(count_q) + n_acc - n_ret);

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      mispred_q <= '0;
      dest_q    <= '0;
      pdest_q   <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      mispred_q <= mispred_d;
      dest_q    <= dest_d;
      pdest_q   <= pdest_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: dispatch, completion, dual retire, flush, wrap and reset.
module tb_rob;
  import rob_pkg::*;

  logic                           clk;
  logic                           reset;
  logic [SCALAR-1:0]              dispatch;
  logic [SCALAR-1:0][RAT_IDX-1:0] dispatch_dest_idx;
  logic [SCALAR-1:0][PRF_IDX-1:0] dispatch_pdest_idx;
  logic [SCALAR-1:0][ROB_IDX-1:0] rob_idx_out;
  logic [1:0]                     rob_avail;
  logic [SCALAR-1:0]              complete;
  logic [SCALAR-1:0][ROB_IDX-1:0] complete_rob_idx;
  logic [SCALAR-1:0]              complete_mispred;
  logic [SCALAR-1:0]              retire;
  logic [SCALAR-1:0][RAT_IDX-1:0] retire_dest_idx_out;
  logic [SCALAR-1:0][PRF_IDX-1:0] retire_pdest_idx_out;
  logic                           flush;

  int n_checks;
  int n_errors;

  rob dut (
    .clk                  (clk),
    .reset                (reset),
    .dispatch             (dispatch),
    .dispatch_dest_idx    (dispatch_dest_idx),
    .dispatch_pdest_idx   (dispatch_pdest_idx),
    .rob_idx_out          (rob_idx_out),
    .rob_avail            (rob_avail),
    .complete             (complete),
    .complete_rob_idx     (complete_rob_idx),
    .complete_mispred     (complete_mispred),
    .retire               (retire),
    .retire_dest_idx_out  (retire_dest_idx_out),
    .retire_pdest_idx_out (retire_pdest_idx_out),
    .flush                (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch           = '0;
    dispatch_dest_idx  = '0;
    dispatch_pdest_idx = '0;
    complete           = '0;
    complete_rob_idx   = '0;
    complete_mispred   = '0;
  endtask

  task automatic disp(input logic [1:0] m, input int d0, input int p0, input int d1,
                      input int p1);
    dispatch              = m;
    dispatch_dest_idx[0]  = RAT_IDX'(d0);
    dispatch_pdest_idx[0] = PRF_IDX'(p0);
    dispatch_dest_idx[1]  = RAT_IDX'(d1);
    dispatch_pdest_idx[1] = PRF_IDX'(p1);
  endtask

  task automatic cmpl(input logic [1:0] m, input int i0, input int i1, input logic [1:0] mp);
    complete            = m;
    complete_rob_idx[0] = ROB_IDX'(i0);
    complete_rob_idx[1] = ROB_IDX'(i1);
    complete_mispred    = mp;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    idle();

    // Reset state
    step();
    step();
    check("rst_retire", 32'(retire), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_avail", 32'(rob_avail), 2);
    check("rst_idx0", 32'(rob_idx_out[0]), 0);
    check("rst_idx1", 32'(rob_idx_out[1]), 0);
    check("rst_count", 32'(dut.count_q), 0);
    reset = 1'b1;
    step();

    // Dual dispatch into entries 0/1
    disp(2'b11, 1, 1, 2, 2);
    #1;
    check("d2_idx0", 32'(rob_idx_out[0]), 0);
    check("d2_idx1", 32'(rob_idx_out[1]), 1);
    step();
    idle();
    check("d2_count", 32'(dut.count_q), 2);
    check("d2_noret", 32'(retire), 0);
    check("d2_avail", 32'(rob_avail), 2);

    // Complete both, dual retire one cycle later
    cmpl(2'b11, 0, 1, 2'b00);
    step();
    idle();
    check("c2_retire", 32'(retire), 3);
    check("c2_dest0", 32'(retire_dest_idx_out[0]), 1);
    check("c2_dest1", 32'(retire_dest_idx_out[1]), 2);
    check("c2_pdest0", 32'(retire_pdest_idx_out[0]), 1);
    check("c2_pdest1", 32'(retire_pdest_idx_out[1]), 2);
    check("c2_flush", 32'(flush), 0);
    step();
    check("c2_count", 32'(dut.count_q), 0);
    check("c2_after", 32'(retire), 0);

    // Younger completes first: no retire until head is done
    disp(2'b11, 3, 10, 4, 11);
    #1;
    check("oo_idx0", 32'(rob_idx_out[0]), 2);
    check("oo_idx1", 32'(rob_idx_out[1]), 3);
    step();
    idle();
    cmpl(2'b01, 3, 0, 2'b00);
    step();
    idle();
    check("oo_wait", 32'(retire), 0);
    cmpl(2'b01, 2, 0, 2'b00);
    step();
    idle();
    check("oo_retire", 32'(retire), 3);
    check("oo_pdest0", 32'(retire_pdest_idx_out[0]), 10);
    check("oo_pdest1", 32'(retire_pdest_idx_out[1]), 11);
    step();
    check("oo_count", 32'(dut.count_q), 0);

    // Way1-only dispatch with ZERO_REG dest; single retire zeroes way1 outputs
    disp(2'b10, 0, 0, int'(ZERO_REG), 20);
    #1;
    check("w1_idx1", 32'(rob_idx_out[1]), 4);
    step();
    idle();
    check("w1_count", 32'(dut.count_q), 1);
    cmpl(2'b10, 0, 4, 2'b00);
    step();
    idle();
    check("w1_retire", 32'(retire), 1);
    check("w1_dest0", 32'(retire_dest_idx_out[0]), 0);
    check("w1_pdest0", 32'(retire_pdest_idx_out[0]), 20);
    check("w1_pdest1", 32'(retire_pdest_idx_out[1]), 0);
    step();
    check("w1_head", 32'(dut.head_q), 5);
    check("w1_tail", 32'(dut.tail_q), 5);

    // Both ways complete entry 6: way1's clear mispred must win
    disp(2'b11, 6, 30, 7, 31);
    step();
    idle();
    cmpl(2'b11, 6, 6, 2'b01);
    step();
    idle();
    cmpl(2'b01, 5, 0, 2'b00);
    step();
    idle();
    check("mw_retire", 32'(retire), 3);
    check("mw_flush", 32'(flush), 0);
    step();

    // Mispredict at head: flush, younger blocked, same-cycle dispatch dropped
    disp(2'b11, 8, 40, 9, 41);
    #1;
    check("mp_idx0", 32'(rob_idx_out[0]), 7);
    step();
    idle();
    cmpl(2'b11, 7, 8, 2'b01);
    step();
    idle();
    disp(2'b11, 12, 12, 13, 13);
    #1;
    check("mp_retire", 32'(retire), 1);
    check("mp_flush", 32'(flush), 1);
    check("mp_pdest0", 32'(retire_pdest_idx_out[0]), 40);
    check("mp_pdest1", 32'(retire_pdest_idx_out[1]), 0);
    step();
    idle();
    check("mp_count", 32'(dut.count_q), 0);
    check("mp_head", 32'(dut.head_q), 0);
    check("mp_tail", 32'(dut.tail_q), 0);
    check("mp_noret", 32'(retire), 0);
    check("mp_noflush", 32'(flush), 0);

    // Fill to full, exercising avail saturation and all-or-nothing dispatch
    for (int i = 0; i < 15; i++) begin
      disp(2'b11, 2 * i, 2 * i + 32, 2 * i + 1, 2 * i + 33);
      #1;
      check("fill_idx0", 32'(rob_idx_out[0]), 32'(2 * i));
      step();
    end
    idle();
    check("fill_c30", 32'(dut.count_q), 30);
    disp(2'b01, 30, 62, 0, 0);
    step();
    idle();
    check("fill_avail1", 32'(rob_avail), 1);
    disp(2'b11, 1, 1, 2, 2);
    step();
    idle();
    check("fill_rej_cnt", 32'(dut.count_q), 31);
    check("fill_rej_tail", 32'(dut.tail_q), 31);
    disp(2'b01, 31, 63, 0, 0);
    #1;
    check("fill_idx31", 32'(rob_idx_out[0]), 31);
    step();
    idle();
    check("full_count", 32'(dut.count_q), 32);
    check("full_avail", 32'(rob_avail), 0);
    disp(2'b11, 1, 1, 2, 2);
    step();
    idle();
    check("full_rej_cnt", 32'(dut.count_q), 32);
    check("full_rej_tail", 32'(dut.tail_q), 0);

    cmpl(2'b11, 0, 1, 2'b00);
    step();
    idle();
    check("full_retire", 32'(retire), 3);
    check("full_pdest0", 32'(retire_pdest_idx_out[0]), 32);
    check("full_dest1", 32'(retire_dest_idx_out[1]), 1);
    check("full_noavail", 32'(rob_avail), 0);
    step();
    check("full_c30", 32'(dut.count_q), 30);
    cmpl(2'b11, 2, 3, 2'b00);
    step();
    idle();
    disp(2'b11, 20, 50, 21, 51);
    #1;
    check("wrap_retire", 32'(retire), 3);
    check("wrap_pdest1", 32'(retire_pdest_idx_out[1]), 35);
    check("wrap_idx0", 32'(rob_idx_out[0]), 0);
    check("wrap_idx1", 32'(rob_idx_out[1]), 1);
    step();
    idle();
    check("wrap_count", 32'(dut.count_q), 30);
    check("wrap_tail", 32'(dut.tail_q), 2);
    check("wrap_head", 32'(dut.head_q), 4);

    // Asynchronous reset mid-operation kills a pending retire at once
    cmpl(2'b01, 4, 0, 2'b00);
    step();
    idle();
    check("ar_pre", 32'(retire), 1);
    reset = 1'b0;
    #1;
    check("ar_retire", 32'(retire), 0);
    check("ar_count", 32'(dut.count_q), 0);
    check("ar_avail", 32'(rob_avail), 2);
    check("ar_flush", 32'(flush), 0);
    step();
    reset = 1'b1;
    step();
    check("ar_post", 32'(retire), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
